// File: rtl/inst_prefetch_unit_if.sv
// Instruction-memory fetch port: req/gnt request channel plus in-order rvalid response channel.
interface inst_prefetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/inst_prefetch_unit.sv
// Fetch engine: issues sequential PCs to imem, buffers in-order responses in a prefetch FIFO and
// presents {pc, inst} to decode; wrong-path responses after a redirect are counted and dropped.
module inst_prefetch_unit #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'hBFC0_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    input  logic                 id_stall,
    inst_prefetch_unit_if.master imem,
    output logic                 if_valid,
    output logic [31:0]          if_pc,
    output logic [31:0]          if_inst
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthC = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StBoot, StRun, StFlush} state_e;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [CntW-1:0] outst_q, outst_d, drop_q, drop_d, count_q, count_d;
    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q, tag_rd_q, tag_wr_q;
    logic [31:0]     fifo_pc_q   [FIFO_DEPTH];
    logic [31:0]     fifo_inst_q [FIFO_DEPTH];
    logic [31:0]     tag_q       [FIFO_DEPTH];
    logic            grant, resp_keep, resp_drop, push, pop;
    logic [CntW:0]   occupancy;
    logic            unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign if_valid = (count_q != '0);
    assign if_pc    = fifo_pc_q[rd_ptr_q];
    assign if_inst  = fifo_inst_q[rd_ptr_q];

    always_comb begin
        // Buffered words plus in-flight requests may never exceed the FIFO, so pushes always fit.
        occupancy = {1'b0, count_q} + {1'b0, outst_q};
        imem.req  = (state_q == StRun) && !redirect_valid && (occupancy < {1'b0, DepthC});
        imem.addr = fetch_pc_q;
        grant     = imem.req && imem.gnt;
        resp_drop = imem.rvalid && (drop_q != '0);
        resp_keep = imem.rvalid && (drop_q == '0);
        push      = resp_keep && !redirect_valid;
        pop       = if_valid && !id_stall && !redirect_valid;
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        count_d    = count_q;
        if (redirect_valid) begin
            // Every in-flight request becomes wrong-path; a response this cycle consumes one of them.
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            outst_d    = '0;
            drop_d     = drop_q + outst_q - CntW'(imem.rvalid);
            count_d    = '0;
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            outst_d = outst_q + CntW'(grant) - CntW'(resp_keep);
            drop_d  = drop_q - CntW'(resp_drop);
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
        case (state_q)
            StBoot:           state_d = StRun;
            StRun, StFlush:   state_d = (drop_d != '0) ? StFlush : StRun;
            default:          state_d = StBoot;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StBoot;
            fetch_pc_q <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            tag_rd_q   <= '0;
            tag_wr_q   <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc_q[i]   <= '0;
                fifo_inst_q[i] <= '0;
                tag_q[i]       <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            if (push) begin
                fifo_pc_q[wr_ptr_q]   <= tag_q[tag_rd_q];
                fifo_inst_q[wr_ptr_q] <= imem.rdata;
            end
            if (grant) begin
                tag_q[tag_wr_q] <= fetch_pc_q;
            end
            if (redirect_valid) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                tag_rd_q <= '0;
                tag_wr_q <= '0;
            end else begin
                if (push)      wr_ptr_q <= wr_ptr_q + PtrW'(1);
                if (pop)       rd_ptr_q <= rd_ptr_q + PtrW'(1);
                if (grant)     tag_wr_q <= tag_wr_q + PtrW'(1);
                if (resp_keep) tag_rd_q <= tag_rd_q + PtrW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !pop && (count_q == DepthC)));
            assert (!imem.rvalid || (outst_q != '0) || (drop_q != '0));
        end
    end

endmodule

// File: tb/tb_inst_prefetch_unit.sv
// Randomised bench for inst_prefetch_unit: an in-order memory with random grant/latency and a
// queue-based model of the architectural instruction stream that decode should see.
module tb_inst_prefetch_unit;
    localparam int unsigned Depth   = 4;
    localparam logic [31:0] ResetPc = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    inst_prefetch_unit_if imem_bus ();

    inst_prefetch_unit #(
        .FIFO_DEPTH (Depth),
        .RESET_PC   (ResetPc)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_stall       (id_stall),
        .imem           (imem_bus),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] mpc;
        int unsigned epoch;
        int unsigned due;
    } pend_t;

    pend_t       pend[$];
    logic [63:0] exp_q[$];
    logic [31:0] model_pc;
    bit          boot;
    int unsigned epoch, cyc;
    int          since_rst, first_valid, grant_cnt, valid_cnt;
    int unsigned n_checks, n_fail;
    int          p_gnt, p_stall, p_redir, lat_min, lat_max;
    bit          rst_req, redir_once, redir_on_rv, watch_pc, saw_wrap;
    logic [31:0] redir_once_pc, first_pc_after_redir;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_cycle();
        int    fresh = 0;
        int    stale = 0;
        bit    exp_req;
        pend_t p, h;
        foreach (pend[i]) begin
            if (pend[i].epoch == epoch) fresh++;
            else stale++;
        end
        exp_req = !boot && (stale == 0) && !redirect_valid && (exp_q.size() + fresh < Depth);
        check_eq("imem_req", 32'(imem_bus.req), 32'(exp_req));
        check_eq("imem_addr", imem_bus.addr, model_pc);
        check_eq("if_valid", 32'(if_valid), 32'(exp_q.size() != 0));
        if (if_valid && exp_q.size() != 0) begin
            check_eq("if_pc", if_pc, exp_q[0][63:32]);
            check_eq("if_inst", if_inst, exp_q[0][31:0]);
        end
        if (since_rst == 0) begin
            check_eq("reset_if_pc", if_pc, 32'h0);
            check_eq("reset_if_inst", if_inst, 32'h0);
        end
        if (if_valid && first_valid < 0) first_valid = since_rst;
        if (if_valid) valid_cnt++;
        if (if_valid && if_pc == 32'h0) saw_wrap = 1'b1;
        if (watch_pc && if_valid) begin
            first_pc_after_redir = if_pc;
            watch_pc = 1'b0;
        end
        if (imem_bus.req && imem_bus.gnt) begin
            grant_cnt++;
            p.addr  = imem_bus.addr;
            p.mpc   = model_pc;
            p.epoch = epoch;
            p.due   = cyc + 1 + lat_min + $urandom_range(lat_max - lat_min);
            pend.push_back(p);
        end
        // Decode consumes the head before this cycle's response lands in the buffer.
        if (exp_q.size() != 0 && !id_stall && !redirect_valid) void'(exp_q.pop_front());
        if (imem_bus.rvalid) begin
            h = pend.pop_front();
            if (h.epoch == epoch && !redirect_valid) exp_q.push_back({h.mpc, mem_word(h.mpc)});
        end
        if (redirect_valid) begin
            exp_q.delete();
            epoch++;
            model_pc = {redirect_pc[31:2], 2'b00};
            watch_pc = 1'b1;
        end else if (exp_req && imem_bus.gnt) begin
            model_pc = model_pc + 32'd4;
        end
        boot = 1'b0;
    endtask

    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            rst             = rst_req;
            id_stall        = ($urandom_range(99) < p_stall);
            imem_bus.gnt    = ($urandom_range(99) < p_gnt);
            imem_bus.rvalid = 1'b0;
            imem_bus.rdata  = $urandom;
            if (!rst && pend.size() != 0 && pend[0].due <= cyc) begin
                imem_bus.rvalid = 1'b1;
                imem_bus.rdata  = mem_word(pend[0].addr);
            end
            redirect_valid = 1'b0;
            redirect_pc    = $urandom;
            if (!rst) begin
                if (redir_once) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = redir_once_pc;
                    redir_once     = 1'b0;
                end else if (redir_on_rv && imem_bus.rvalid) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = 32'h0000_1002;
                    redir_on_rv    = 1'b0;
                end else if ($urandom_range(99) < p_redir) begin
                    redirect_valid = 1'b1;
                    if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFE0 | 32'($urandom_range(31));
                end
            end
            #1;
            if (rst) begin
                pend.delete();
                exp_q.delete();
                model_pc    = ResetPc;
                boot        = 1'b1;
                since_rst   = 0;
                first_valid = -1;
                grant_cnt   = 0;
                valid_cnt   = 0;
                watch_pc    = 1'b0;
            end else begin
                check_cycle();
                since_rst++;
            end
            cyc++;
        end
    endtask

    task automatic do_reset();
        rst_req = 1'b1;
        run_cycles(2);
        rst_req = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; epoch = 0;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_stall = 1'b0;
        imem_bus.gnt = 1'b0; imem_bus.rvalid = 1'b0; imem_bus.rdata = '0;
        p_gnt = 100; p_stall = 0; p_redir = 0; lat_min = 0; lat_max = 0;
        redir_once = 1'b0; redir_on_rv = 1'b0; saw_wrap = 1'b0; watch_pc = 1'b0;
        first_pc_after_redir = '0;

        // Single-cycle memory: first instruction on cycle 3, then one per cycle.
        do_reset();
        run_cycles(16);
        check_eq("first_valid_cycle", 32'(first_valid), 32'd3);
        check_eq("valid_cycles", 32'(valid_cnt), 32'd13);
        check_eq("grants_streaming", 32'(grant_cnt), 32'd15);

        // Decode stalled: exactly Depth requests, then drain on release.
        p_stall = 100;
        do_reset();
        run_cycles(12);
        check_eq("grants_stalled", 32'(grant_cnt), 32'(Depth));
        p_stall = 0;
        run_cycles(12);

        // Three requests in flight with slow memory, then a misaligned redirect.
        lat_min = 6; lat_max = 6;
        do_reset();
        run_cycles(4);
        lat_min = 0; lat_max = 0;
        redir_once = 1'b1; redir_once_pc = 32'h0040_0103;
        run_cycles(20);
        check_eq("redirect_first_pc", first_pc_after_redir, 32'h0040_0100);

        // Redirect in the same cycle as a response.
        redir_on_rv = 1'b1;
        run_cycles(15);
        check_eq("redirect_on_rvalid_pc", first_pc_after_redir, 32'h0000_1000);

        // Grant withheld near the top of the address space, then wrap to zero.
        p_gnt = 0;
        redir_once = 1'b1; redir_once_pc = 32'hFFFF_FFF4;
        run_cycles(7);
        p_gnt = 100;
        run_cycles(12);
        check_eq("pc_wrap_seen", 32'(saw_wrap), 32'd1);

        // Reset mid-stream with a full FIFO, then restart.
        p_stall = 100;
        run_cycles(10);
        p_stall = 0;
        do_reset();
        run_cycles(16);
        check_eq("restart_first_valid", 32'(first_valid), 32'd3);

        // Randomised traffic.
        for (int k = 0; k < 3; k++) begin
            p_gnt = 50 + 20 * k; p_stall = 40 - 10 * k; p_redir = 3 + k;
            lat_min = 0; lat_max = 4 - k;
            do_reset();
            run_cycles(3000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
